// File: rtl/led_pkg.sv
// Shared types and helpers for the multi-channel LED driver.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_OFF = 2'd0,
    S_ON  = 2'd1,
    S_HI  = 2'd2,
    S_LO  = 2'd3
  } state_e;

  // Width of a counter spanning 0..div-1; never less than 1 bit.
  function automatic int unsigned presc_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: mode/half-period registers, phase counter, flash counter
// and the OFF/ON/HI/LO state machine.
module led_channel
  import led_pkg::*;
#(
  parameter int unsigned PER_W = 12,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             wr_hit,
  input  logic [1:0]       mode,
  input  logic [PER_W-1:0] half,
  input  logic [CNT_W-1:0] count,
  output logic             led,
  output logic             busy
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [PER_W-1:0] half_q, half_d;
  logic [PER_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] flash_q, flash_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OFF;
      mode_q  <= MODE_OFF;
      half_q  <= '0;
      phase_q <= '0;
      flash_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      half_q  <= half_d;
      phase_q <= phase_d;
      flash_q <= flash_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    half_d  = half_q;
    phase_d = phase_q;
    flash_d = flash_q;
    // A write takes priority over a coincident tick, which is dropped.
    if (wr_hit) begin
      mode_d  = mode_e'(mode);
      half_d  = (half == '0) ? PER_W'(1) : half;
      phase_d = '0;
      flash_d = '0;
      case (mode_e'(mode))
        MODE_OFF:   state_d = S_OFF;
        MODE_ON:    state_d = S_ON;
        MODE_BLINK: state_d = S_HI;
        MODE_BURST: begin
          if (count != '0) begin
            state_d = S_HI;
            flash_d = count;
          end else begin
            state_d = S_OFF;
          end
        end
        default:    state_d = S_OFF;
      endcase
    end else if (tick && (state_q == S_HI || state_q == S_LO)) begin
      if (phase_q == half_q - 1'b1) begin
        phase_d = '0;
        if (state_q == S_HI) begin
          state_d = S_LO;
        end else if (mode_q == MODE_BURST) begin
          if (flash_q <= CNT_W'(1)) begin
            state_d = S_OFF;
            flash_d = '0;
          end else begin
            state_d = S_HI;
            flash_d = flash_q - 1'b1;
          end
        end else begin
          state_d = S_HI;
        end
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end
  end

  assign led  = (state_q == S_ON) || (state_q == S_HI);
  assign busy = (mode_q == MODE_BURST) && (flash_q != '0);

endmodule

// File: rtl/led_blink_multi.sv
// Multi-channel LED driver: shared free-running prescaler, write address
// decode and one led_channel per LED.
module led_blink_multi
  import led_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 1000,
  parameter int unsigned NUM_LED = 4,
  parameter int unsigned PER_W   = 12,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned ADDR_W  = 4
) (
  input  logic               CLK_50M,
  input  logic               RST_N,
  input  logic               WR_EN,
  input  logic [ADDR_W-1:0]  WR_ADDR,
  input  logic [1:0]         WR_MODE,
  input  logic [PER_W-1:0]   WR_HALF,
  input  logic [CNT_W-1:0]   WR_COUNT,
  output logic [NUM_LED-1:0] LED,
  output logic [NUM_LED-1:0] BUSY,
  output logic               TICK
);

  localparam int unsigned      DIV       = CLK_HZ / TICK_HZ;
  localparam int unsigned      PW        = presc_width(DIV);
  localparam logic [PW-1:0]    PRESC_MAX = PW'(DIV - 1);

  logic [PW-1:0]      presc_q, presc_d;
  logic [NUM_LED-1:0] wr_hit;

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) presc_q <= '0;
    else        presc_q <= presc_d;
  end

  always_comb begin
    presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
  end

  assign TICK = (presc_q == PRESC_MAX);

  // Out-of-range addresses match no channel and are therefore ignored.
  always_comb begin
    wr_hit = '0;
    for (int unsigned i = 0; i < NUM_LED; i++) begin
      wr_hit[i] = WR_EN && (WR_ADDR == ADDR_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_LED; g++) begin : g_ch
    led_channel #(
      .PER_W (PER_W),
      .CNT_W (CNT_W)
    ) u_ch (
      .clk    (CLK_50M),
      .rst_n  (RST_N),
      .tick   (TICK),
      .wr_hit (wr_hit[g]),
      .mode   (WR_MODE),
      .half   (WR_HALF),
      .count  (WR_COUNT),
      .led    (LED[g]),
      .busy   (BUSY[g])
    );
  end

endmodule

// File: tb/tb_led_blink_multi.sv
// Directed self-checking bench for led_blink_multi (TICK every 10 cycles).
module tb_led_blink_multi;

  logic        CLK_50M = 1'b0;
  logic        RST_N   = 1'b0;
  logic        WR_EN   = 1'b0;
  logic [3:0]  WR_ADDR = '0;
  logic [1:0]  WR_MODE = '0;
  logic [11:0] WR_HALF = '0;
  logic [7:0]  WR_COUNT = '0;
  logic [3:0]  LED;
  logic [3:0]  BUSY;
  logic        TICK;

  int n_checks = 0;
  int n_fail   = 0;

  led_blink_multi #(
    .CLK_HZ  (1000),
    .TICK_HZ (100),
    .NUM_LED (4),
    .PER_W   (12),
    .CNT_W   (8),
    .ADDR_W  (4)
  ) dut (
    .CLK_50M  (CLK_50M),
    .RST_N    (RST_N),
    .WR_EN    (WR_EN),
    .WR_ADDR  (WR_ADDR),
    .WR_MODE  (WR_MODE),
    .WR_HALF  (WR_HALF),
    .WR_COUNT (WR_COUNT),
    .LED      (LED),
    .BUSY     (BUSY),
    .TICK     (TICK)
  );

  always #5 CLK_50M = ~CLK_50M;

  // Called at a negedge; returns at the next negedge with the write applied.
  task automatic do_write(input logic [3:0] addr, input logic [1:0] mode,
                          input logic [11:0] half, input logic [7:0] cnt);
    WR_EN = 1'b1; WR_ADDR = addr; WR_MODE = mode; WR_HALF = half; WR_COUNT = cnt;
    @(negedge CLK_50M);
    WR_EN = 1'b0;
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (TICK === 1'b1) begin ok = 1'b1; break; end
      @(negedge CLK_50M);
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL wait_tick: TICK never seen within 40 cycles");
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (5) @(negedge CLK_50M);
    n_checks++;
    if (LED !== 4'b0 || BUSY !== 4'b0 || TICK !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: LED=%b BUSY=%b TICK=%b, want 0000 0000 0", LED, BUSY, TICK);
    end
    RST_N = 1'b1;
    // After n rising edges the prescaler holds n mod 10; TICK when it is 9.
    for (int n = 0; n < 35; n++) begin
      n_checks++;
      if (TICK !== ((n % 10) == 9) || LED !== 4'b0 || BUSY !== 4'b0) begin
        n_fail++;
        $display("FAIL reset_tick_n%0d: TICK=%b LED=%b BUSY=%b, want TICK=%b LED=0 BUSY=0",
                 n, TICK, LED, BUSY, (n % 10) == 9);
      end
      @(negedge CLK_50M);
    end
  endtask

  task automatic test_on_off();
    do_write(4'd1, 2'd1, 12'd0, 8'd0);
    n_checks++;
    if (LED !== 4'b0010) begin
      n_fail++; $display("FAIL ch1_on: LED=%b want 0010", LED);
    end
    repeat (7) @(negedge CLK_50M);
    n_checks++;
    if (LED !== 4'b0010) begin
      n_fail++; $display("FAIL ch1_on_steady: LED=%b want 0010", LED);
    end
    do_write(4'd1, 2'd0, 12'd0, 8'd0);
    n_checks++;
    if (LED !== 4'b0000 || BUSY !== 4'b0000) begin
      n_fail++; $display("FAIL ch1_off: LED=%b BUSY=%b want 0000 0000", LED, BUSY);
    end
  endtask

  task automatic test_blink();
    int  last_rise, cyc, rises;
    logic prev;
    do_write(4'd0, 2'd2, 12'd3, 8'd0);
    n_checks++;
    if (LED !== 4'b0001) begin
      n_fail++; $display("FAIL blink_start: LED=%b want 0001", LED);
    end
    prev = LED[0]; cyc = 0; rises = 0; last_rise = 0;
    while (rises < 6 && cyc < 600) begin
      @(negedge CLK_50M); cyc++;
      if (LED[0] === 1'b1 && prev === 1'b0) begin
        if (rises > 0) begin
          n_checks++;
          if ((cyc - last_rise) < 51 || (cyc - last_rise) > 69) begin
            n_fail++;
            $display("FAIL blink_period%0d: %0d cycles, want 60+-9", rises, cyc - last_rise);
          end
        end
        last_rise = cyc; rises++;
      end
      if (LED[3:1] !== 3'b000) begin
        n_checks++; n_fail++;
        $display("FAIL blink_others: LED=%b want 000x", LED);
      end
      prev = LED[0];
    end
    n_checks++;
    if (rises != 6) begin
      n_fail++; $display("FAIL blink_rises: %0d rising edges, want 6", rises);
    end
    do_write(4'd0, 2'd0, 12'd0, 8'd0);
  endtask

  task automatic test_burst();
    int   ticks, rises, cyc;
    logic prev;
    bit   tick_seen, bad;
    do_write(4'd2, 2'd3, 12'd1, 8'd3);
    n_checks++;
    if (BUSY !== 4'b0100 || LED !== 4'b0100) begin
      n_fail++; $display("FAIL burst_start: LED=%b BUSY=%b want 0100 0100", LED, BUSY);
    end
    ticks = 0; rises = 1; cyc = 0; prev = LED[2];
    while (BUSY[2] === 1'b1 && cyc < 200) begin
      tick_seen = (TICK === 1'b1);
      @(negedge CLK_50M); cyc++;
      if (tick_seen) ticks++;
      if (LED[2] === 1'b1 && prev === 1'b0) rises++;
      prev = LED[2];
    end
    n_checks++;
    if (ticks != 6) begin
      n_fail++; $display("FAIL burst_busy_fall: BUSY fell after %0d ticks, want 6", ticks);
    end
    n_checks++;
    if (rises != 3) begin
      n_fail++; $display("FAIL burst_flashes: %0d rising edges, want 3", rises);
    end
    bad = 1'b0;
    repeat (200) begin
      @(negedge CLK_50M);
      if (LED !== 4'b0 || BUSY !== 4'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++; $display("FAIL burst_idle: LED=%b BUSY=%b, want 0 for 20 ticks", LED, BUSY);
    end
  endtask

  task automatic test_boundary();
    bit   ok, bad;
    logic prev;
    do_write(4'd3, 2'd3, 12'd4, 8'd0);
    n_checks++;
    if (LED !== 4'b0 || BUSY !== 4'b0) begin
      n_fail++; $display("FAIL burst_cnt0: LED=%b BUSY=%b want 0000 0000", LED, BUSY);
    end
    do_write(4'd3, 2'd2, 12'd0, 8'd0);
    n_checks++;
    if (LED !== 4'b1000) begin
      n_fail++; $display("FAIL half0_start: LED=%b want 1000", LED);
    end
    for (int k = 0; k < 4; k++) begin
      wait_tick(ok);
      if (!ok) break;
      prev = LED[3];
      @(negedge CLK_50M);
      n_checks++;
      if (LED[3] !== ~prev) begin
        n_fail++; $display("FAIL half0_toggle%0d: LED3=%b want %b", k, LED[3], ~prev);
      end
    end
    do_write(4'd3, 2'd0, 12'd0, 8'd0);
    do_write(4'd5, 2'd1, 12'd0, 8'd0);
    bad = 1'b0;
    repeat (15) begin
      if (LED !== 4'b0 || BUSY !== 4'b0) bad = 1'b1;
      @(negedge CLK_50M);
    end
    n_checks++;
    if (bad) begin
      n_fail++; $display("FAIL addr5_ignored: LED=%b BUSY=%b want 0000 0000", LED, BUSY);
    end
  endtask

  task automatic test_restart();
    bit ok;
    int hi;
    do_write(4'd0, 2'd2, 12'd5, 8'd0);
    repeat (23) @(negedge CLK_50M);
    wait_tick(ok);
    // Write lands on the same edge as the tick: the tick must not count.
    do_write(4'd0, 2'd2, 12'd5, 8'd0);
    n_checks++;
    if (LED !== 4'b0001) begin
      n_fail++; $display("FAIL restart_led: LED=%b want 0001", LED);
    end
    hi = 0;
    while (LED[0] === 1'b1 && hi < 100) begin
      hi++;
      @(negedge CLK_50M);
    end
    n_checks++;
    if (hi != 50) begin
      n_fail++; $display("FAIL restart_phase: high for %0d cycles, want 50", hi);
    end
    do_write(4'd0, 2'd0, 12'd0, 8'd0);
  endtask

  task automatic test_async_reset();
    do_write(4'd1, 2'd1, 12'd0, 8'd0);
    do_write(4'd2, 2'd3, 12'd2, 8'd5);
    repeat (25) @(negedge CLK_50M);
    n_checks++;
    if (LED[1] !== 1'b1 || BUSY !== 4'b0100) begin
      n_fail++; $display("FAIL pre_reset: LED=%b BUSY=%b want x01x(bit1=1) 0100", LED, BUSY);
    end
    #2 RST_N = 1'b0;
    #1;
    n_checks++;
    if (LED !== 4'b0 || BUSY !== 4'b0 || TICK !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: LED=%b BUSY=%b TICK=%b want 0000 0000 0", LED, BUSY, TICK);
    end
    @(negedge CLK_50M);
    RST_N = 1'b1;
    @(negedge CLK_50M);
    n_checks++;
    if (LED !== 4'b0 || BUSY !== 4'b0) begin
      n_fail++; $display("FAIL post_reset: LED=%b BUSY=%b want 0000 0000", LED, BUSY);
    end
  endtask

  initial begin
    @(negedge CLK_50M);
    test_reset();
    test_on_off();
    test_blink();
    test_burst();
    test_boundary();
    test_restart();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
